// File: rtl/eth_pkg.sv
// Shared constants, FSM state type and bit-reversal helper for the Ethernet RX FCS checker.
package eth_pkg;

    localparam logic [31:0] CRC32_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        STREAM
    } fsm_state_t;

    function automatic logic [31:0] bitrev32(input logic [31:0] x);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[i] = x[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// One-byte CRC-32 update, non-reflected register, data bits consumed LSB first (wire order).
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] crc_work;

    always_comb begin
        crc_work = crc_in;
        for (int i = 0; i < 8; i++) begin
            crc_work = {crc_work[30:0], 1'b0} ^ ((crc_work[31] ^ data[i]) ? CRC32_POLY : 32'h0);
        end
        crc_out = crc_work;
    end

endmodule

// File: rtl/eth_rx_fcs_check.sv
// RX FCS checker: holds back the last 4 bytes of each frame, CRCs the payload, strips the FCS
// and reports each frame good/bad with cause bits and saturating frame counters.
module eth_rx_fcs_check
    import eth_pkg::*;
#(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int CNT_W   = 16
) (
    input  logic             i_sys_clk,
    input  logic             i_rstn,
    input  logic [7:0]       i_data,
    input  logic             i_valid,
    input  logic             i_last,
    input  logic             i_rx_err,
    output logic [7:0]       o_data,
    output logic             o_valid,
    output logic             o_last,
    output logic             o_good,
    output logic             o_bad,
    output logic             o_err_fcs,
    output logic             o_err_len,
    output logic [CNT_W-1:0] o_good_cnt,
    output logic [CNT_W-1:0] o_bad_cnt
);

    localparam int LEN_W = $clog2(MAX_LEN + 2) + 1;

    fsm_state_t       state_reg;
    logic [2:0]       fill_reg;
    logic [31:0]      dl_reg;
    logic [31:0]      dl_next;
    logic [31:0]      crc_reg;
    logic [31:0]      crc_upd;
    logic [LEN_W-1:0] len_reg;
    logic [LEN_W-1:0] len_now;
    logic             rx_err_reg;

    logic             rx_err_any;
    logic             len_bad;
    logic [31:0]      fcs_rx;
    logic [31:0]      fcs_exp;
    logic             fcs_ok;
    logic             frame_end;
    logic             runt;
    logic             frame_good;
    logic             good_evt;
    logic             bad_evt;

    // Byte 0 of the delay line is the newest byte, byte 3 the oldest (next payload byte out).
    assign dl_next[7:0] = i_data;
    for (genvar gi = 1; gi < 4; gi++) begin : g_delay
        assign dl_next[gi*8 +: 8] = dl_reg[(gi-1)*8 +: 8];
    end

    crc32_d8 u_crc (
        .crc_in  (crc_reg),
        .data    (dl_reg[31:24]),
        .crc_out (crc_upd)
    );

    assign len_now    = (&len_reg) ? len_reg : len_reg + 1'b1;
    assign len_bad    = (len_now < LEN_W'(MIN_LEN)) || (len_now > LEN_W'(MAX_LEN));
    assign rx_err_any = rx_err_reg | i_rx_err;

    // The FCS was sent byte0 first; byte0 is now the oldest held byte after the outgoing one.
    assign fcs_rx  = {i_data, dl_reg[7:0], dl_reg[15:8], dl_reg[23:16]};
    assign fcs_exp = ~bitrev32(crc_upd);
    assign fcs_ok  = (fcs_rx == fcs_exp);

    // A frame of 4 bytes or fewer never reaches STREAM and so carries no payload at all.
    assign frame_end  = i_valid && i_last && (state_reg == STREAM);
    assign runt       = i_valid && i_last && (state_reg != STREAM);
    assign frame_good = fcs_ok && !rx_err_any && !len_bad;
    assign good_evt   = frame_end && frame_good;
    assign bad_evt    = (frame_end && !frame_good) || runt;

    always_ff @(posedge i_sys_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_reg  <= IDLE;
            fill_reg   <= '0;
            dl_reg     <= '0;
            crc_reg    <= CRC32_INIT;
            len_reg    <= '0;
            rx_err_reg <= 1'b0;
            o_data     <= '0;
            o_valid    <= 1'b0;
            o_last     <= 1'b0;
            o_good     <= 1'b0;
            o_bad      <= 1'b0;
            o_err_fcs  <= 1'b0;
            o_err_len  <= 1'b0;
        end else begin
            o_valid   <= 1'b0;
            o_last    <= 1'b0;
            o_good    <= good_evt;
            o_bad     <= bad_evt;
            o_err_fcs <= frame_end && !fcs_ok;
            o_err_len <= (frame_end && len_bad) || runt;

            if (i_valid) begin
                dl_reg     <= dl_next;
                len_reg    <= len_now;
                rx_err_reg <= rx_err_any;

                if (state_reg == STREAM) begin
                    o_data  <= dl_reg[31:24];
                    o_valid <= 1'b1;
                    crc_reg <= crc_upd;
                end

                if (i_last) begin
                    // Clear everything in this edge so the next frame may start on the next cycle.
                    state_reg  <= IDLE;
                    fill_reg   <= '0;
                    crc_reg    <= CRC32_INIT;
                    len_reg    <= '0;
                    rx_err_reg <= 1'b0;
                    o_last     <= frame_end;
                end else begin
                    case (state_reg)
                        IDLE: begin
                            state_reg <= FILL;
                            fill_reg  <= 3'd1;
                        end
                        FILL: begin
                            fill_reg <= fill_reg + 3'd1;
                            if (fill_reg == 3'd3) begin
                                state_reg <= STREAM;
                            end
                        end
                        default: begin
                            state_reg <= STREAM;
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_good_cnt <= '0;
            o_bad_cnt  <= '0;
        end else begin
            if (good_evt && !(&o_good_cnt)) begin
                o_good_cnt <= o_good_cnt + 1'b1;
            end
            if (bad_evt && !(&o_bad_cnt)) begin
                o_bad_cnt <= o_bad_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Directed bench for eth_rx_fcs_check: frame-level reference model feeding an expected-event queue.
module tb_eth_rx_fcs_check;

    localparam int MIN_LEN = 4;
    localparam int MAX_LEN = 1518;
    localparam int CNT_W   = 16;

    logic             i_sys_clk = 1'b0;
    logic             i_rstn    = 1'b0;
    logic [7:0]       i_data    = 8'h00;
    logic             i_valid   = 1'b0;
    logic             i_last    = 1'b0;
    logic             i_rx_err  = 1'b0;
    logic [7:0]       o_data;
    logic             o_valid;
    logic             o_last;
    logic             o_good;
    logic             o_bad;
    logic             o_err_fcs;
    logic             o_err_len;
    logic [CNT_W-1:0] o_good_cnt;
    logic [CNT_W-1:0] o_bad_cnt;

    eth_rx_fcs_check #(
        .MIN_LEN (MIN_LEN),
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .i_sys_clk  (i_sys_clk),
        .i_rstn     (i_rstn),
        .i_data     (i_data),
        .i_valid    (i_valid),
        .i_last     (i_last),
        .i_rx_err   (i_rx_err),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_last     (o_last),
        .o_good     (o_good),
        .o_bad      (o_bad),
        .o_err_fcs  (o_err_fcs),
        .o_err_len  (o_err_len),
        .o_good_cnt (o_good_cnt),
        .o_bad_cnt  (o_bad_cnt)
    );

    always #5 i_sys_clk = ~i_sys_clk;

    typedef struct packed {
        logic       v;
        logic [7:0] d;
        logic       last;
        logic       good;
        logic       bad;
        logic       efcs;
        logic       elen;
    } ev_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         exp_good = 0;
    int         exp_bad  = 0;
    int         first_v_cyc = -1;
    int         start_cyc   = 0;
    bit         chk_en = 1'b0;
    ev_t        exq[$];
    ev_t        st;
    logic [7:0] cap_q[$];
    logic [7:0] frm[$];

    always @(posedge i_sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference CRC-32 in the usual reflected form; returns the value whose low byte goes out first.
    function automatic logic [31:0] m_crc(input logic [7:0] q[$]);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (q[i]) begin
            c = c ^ {24'h0, q[i]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    task automatic add_fcs();
        logic [31:0] c;
        c = m_crc(frm);
        frm.push_back(c[7:0]);
        frm.push_back(c[15:8]);
        frm.push_back(c[23:16]);
        frm.push_back(c[31:24]);
    endtask

    task automatic load_t1();
        frm = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
               8'h26, 8'h39, 8'hF4, 8'hCB};
    endtask

    task automatic model_push(input int err_idx);
        int          n;
        logic [7:0]  p[$];
        logic [31:0] rx_fcs;
        bit          ok, elen, err, good;
        ev_t         e;
        n = frm.size();
        if (n <= 4) begin
            e = '{v: 1'b0, d: 8'h00, last: 1'b0, good: 1'b0, bad: 1'b1, efcs: 1'b0, elen: 1'b1};
            exq.push_back(e);
        end else begin
            p = {};
            for (int i = 0; i < n - 4; i++) p.push_back(frm[i]);
            rx_fcs = {frm[n-1], frm[n-2], frm[n-3], frm[n-4]};
            ok   = (m_crc(p) == rx_fcs);
            elen = (n < MIN_LEN) || (n > MAX_LEN);
            err  = (err_idx >= 0) && (err_idx < n);
            good = ok && !err && !elen;
            for (int i = 0; i < n - 4; i++) begin
                e = '{v: 1'b1, d: p[i], last: 1'b0, good: 1'b0, bad: 1'b0, efcs: 1'b0, elen: 1'b0};
                if (i == n - 5) begin
                    e.last = 1'b1;
                    e.good = good;
                    e.bad  = !good;
                    e.efcs = !ok;
                    e.elen = elen;
                end
                exq.push_back(e);
            end
        end
    endtask

    task automatic drive_byte(input logic [7:0] d, input bit last, input bit err, input bit gaps);
        if (gaps) begin
            while ($urandom_range(1, 0) == 1) begin
                @(negedge i_sys_clk);
                i_valid  = 1'b0;
                i_last   = 1'b0;
                i_rx_err = 1'b0;
                i_data   = 8'($urandom);
            end
        end
        @(negedge i_sys_clk);
        i_valid  = 1'b1;
        i_data   = d;
        i_last   = last;
        i_rx_err = err;
    endtask

    task automatic send_frame(input int err_idx, input bit gaps);
        int n;
        n = frm.size();
        model_push(err_idx);
        for (int i = 0; i < n; i++) begin
            drive_byte(frm[i], i == n - 1, i == err_idx, gaps);
            if (i == 0) start_cyc = cyc;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge i_sys_clk);
            i_valid  = 1'b0;
            i_last   = 1'b0;
            i_rx_err = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exq.size() != 0 && k < 50) begin
            @(negedge i_sys_clk);
            k++;
        end
        if (exq.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d events pending expected 0", name, exq.size());
            exq = {};
        end
        idle(2);
    endtask

    function automatic logic [71:0] cap_t1();
        logic [71:0] r;
        r = '0;
        foreach (cap_q[i]) r = {r[63:0], cap_q[i]};
        return r;
    endfunction

    always @(negedge i_sys_clk) begin
        ev_t a, e;
        if (chk_en) begin
            a = '{v: o_valid, d: (o_valid ? o_data : 8'h00), last: o_last, good: o_good,
                  bad: o_bad, efcs: o_err_fcs, elen: o_err_len};
            if (o_valid || o_good || o_bad) begin
                if (o_valid) begin
                    cap_q.push_back(o_data);
                    if (first_v_cyc < 0) first_v_cyc = cyc;
                end
                if (o_good || o_bad) st = a;
                if (exq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %0h expected none", a);
                end else begin
                    e = exq.pop_front();
                    check("out_event", 128'(a), 128'(e));
                    if (e.good) exp_good++;
                    if (e.bad)  exp_bad++;
                    check("good_cnt", 128'(o_good_cnt), 128'(exp_good));
                    check("bad_cnt",  128'(o_bad_cnt),  128'(exp_bad));
                end
            end else begin
                check("quiet", 128'({o_last, o_err_fcs, o_err_len}), 128'(0));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge i_sys_clk);
        check("reset_outs", 128'({o_valid, o_last, o_good, o_bad, o_err_fcs, o_err_len, o_data}), 128'(0));
        check("reset_cnts", 128'({o_good_cnt, o_bad_cnt}), 128'(0));
        i_rstn = 1'b1;
        chk_en = 1'b1;
        idle(2);

        frm = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        check("model_crc", 128'(m_crc(frm)), 128'(32'hCBF4_3926));

        // Test 1: "123456789" with correct FCS, also pins the 5-cycle first-byte latency.
        load_t1();
        cap_q = {};
        first_v_cyc = -1;
        send_frame(-1, 1'b0);
        idle(1);
        drain("t1");
        check("t1_latency", 128'(first_v_cyc), 128'(start_cyc + 5));
        check("t1_data", 128'(cap_t1()), 128'(72'h31_32_33_34_35_36_37_38_39));
        check("t1_status", 128'({st.last, st.good, st.bad}), 128'(3'b110));
        check("t1_good_cnt", 128'(o_good_cnt), 128'(1));

        // Test 2: corrupted FCS byte0.
        load_t1();
        frm[9] = 8'h27;
        cap_q = {};
        send_frame(-1, 1'b0);
        idle(1);
        drain("t2");
        check("t2_data", 128'(cap_t1()), 128'(72'h31_32_33_34_35_36_37_38_39));
        check("t2_status", 128'({st.bad, st.efcs, st.elen}), 128'(3'b110));
        check("t2_bad_cnt", 128'(o_bad_cnt), 128'(1));

        // Test 3: 64-byte zero frame then test-1 frame back to back.
        frm = {};
        for (int i = 0; i < 60; i++) frm.push_back(8'h00);
        add_fcs();
        cap_q = {};
        send_frame(-1, 1'b0);
        load_t1();
        send_frame(-1, 1'b0);
        idle(1);
        drain("t3");
        check("t3_bytes", 128'(cap_q.size()), 128'(69));
        check("t3_good_cnt", 128'(o_good_cnt), 128'(3));

        // Test 4: 3-byte runt.
        frm = {8'hAA, 8'hBB, 8'hCC};
        cap_q = {};
        send_frame(-1, 1'b0);
        idle(1);
        drain("t4");
        check("t4_bytes", 128'(cap_q.size()), 128'(0));
        check("t4_status", 128'({st.v, st.last, st.bad, st.efcs, st.elen}), 128'(5'b00101));
        check("t4_bad_cnt", 128'(o_bad_cnt), 128'(2));

        // Test 5: test-1 frame with random idle gaps.
        load_t1();
        cap_q = {};
        send_frame(-1, 1'b1);
        idle(1);
        drain("t5");
        check("t5_data", 128'(cap_t1()), 128'(72'h31_32_33_34_35_36_37_38_39));
        check("t5_good_cnt", 128'(o_good_cnt), 128'(4));

        // Shortest non-runt frame: one payload byte.
        frm = {8'h5A};
        add_fcs();
        cap_q = {};
        send_frame(-1, 1'b0);
        idle(1);
        drain("min5");
        check("min5_good_cnt", 128'(o_good_cnt), 128'(5));

        // Oversize frame (MAX_LEN+1) with correct FCS: forwarded in full, then length error.
        frm = {};
        for (int i = 0; i < MAX_LEN - 3; i++) frm.push_back(8'(i * 13 + 1));
        add_fcs();
        cap_q = {};
        send_frame(-1, 1'b0);
        idle(1);
        drain("oversize");
        check("oversize_bytes", 128'(cap_q.size()), 128'(MAX_LEN - 3));
        check("oversize_status", 128'({st.bad, st.efcs, st.elen}), 128'(3'b101));

        // Test 6: rx_err on byte 5 of an otherwise valid 64-byte frame.
        frm = {};
        for (int i = 0; i < 60; i++) frm.push_back(8'(i * 7));
        add_fcs();
        send_frame(5, 1'b0);
        idle(1);
        drain("t6");
        check("t6_status", 128'({st.bad, st.efcs, st.elen}), 128'(3'b100));
        check("t6_bad_cnt", 128'(o_bad_cnt), 128'(4));

        // Reset in the middle of a frame.
        chk_en = 1'b0;
        for (int i = 0; i < 12; i++) drive_byte(8'(i + 8'h40), 1'b0, 1'b0, 1'b0);
        @(negedge i_sys_clk);
        i_valid = 1'b0;
        i_rstn  = 1'b0;
        #1;
        check("abort_outs", 128'({o_valid, o_last, o_good, o_bad, o_err_fcs, o_err_len, o_data}), 128'(0));
        check("abort_cnts", 128'({o_good_cnt, o_bad_cnt}), 128'(0));
        repeat (2) @(negedge i_sys_clk);
        i_rstn   = 1'b1;
        exq      = {};
        exp_good = 0;
        exp_bad  = 0;
        chk_en   = 1'b1;
        idle(10);
        check("post_reset_cnts", 128'({o_good_cnt, o_bad_cnt}), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
